// File: rtl/cv32e40p_prio_int_controller.sv
// Priority interrupt controller: level/edge lines, threshold, highest-priority pick (ties -> highest index).
// Latency irq_i->irq_req_o: level 2, edge 3 cycles (+1 with CV32E40P_IRQ_SYNC_EN); irq_wu_o is combinational.
// Backpressure: an offer is held stable in REQ until irq_ack_i, or retracted when the line stops being eligible.
module cv32e40p_prio_int_controller #(
    parameter int NUM_INTERRUPTS = 32,
    parameter int PRIO_WIDTH     = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_INTERRUPTS-1:0]            irq_i,
    input  logic [NUM_INTERRUPTS-1:0]            irq_edge_i,
    input  logic [NUM_INTERRUPTS*PRIO_WIDTH-1:0] irq_prio_i,
    input  logic [NUM_INTERRUPTS-1:0]            irq_enable_i,
    input  logic                                 global_ie_i,
    input  logic [PRIO_WIDTH-1:0]                threshold_i,
    input  logic                                 irq_ack_i,
    output logic                                 irq_req_o,
    output logic [4:0]                           irq_id_o,
    output logic [PRIO_WIDTH-1:0]                irq_prio_o,
    output logic [NUM_INTERRUPTS-1:0]            pending_o,
    output logic                                 irq_wu_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACKED
    } state_e;

    state_e                    state_q, state_d;
    logic [NUM_INTERRUPTS-1:0] irq_q, irq_prev_q;
    logic [NUM_INTERRUPTS-1:0] pend_q, pend_d, pend_clr;
    logic [4:0]                irq_id_q, irq_id_d;
    logic [PRIO_WIDTH-1:0]     irq_prio_q, irq_prio_d;
    logic [PRIO_WIDTH-1:0]     line_prio [NUM_INTERRUPTS];
    logic [NUM_INTERRUPTS-1:0] cand;
    logic                      win_found;
    logic [4:0]                win_id;
    logic [PRIO_WIDTH-1:0]     win_prio;
    logic                      lat_cand, lat_edge, ack_take;

`ifdef CV32E40P_IRQ_SYNC_EN
    // First synchronizer stage; irq_q acts as the second stage.
    logic [NUM_INTERRUPTS-1:0] irq_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync_q <= '0;
            irq_q      <= '0;
        end else begin
            irq_sync_q <= irq_i;
            irq_q      <= irq_sync_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_i;
        end
    end
`endif

    assign irq_wu_o = |(irq_i & irq_enable_i);

    always_comb begin
        for (int k = 0; k < NUM_INTERRUPTS; k++) begin
            line_prio[k] = irq_prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
        end
    end

    assign pending_o = (irq_edge_i & pend_q) | (~irq_edge_i & irq_q);

    always_comb begin
        for (int k = 0; k < NUM_INTERRUPTS; k++) begin
            cand[k] = pending_o[k] & irq_enable_i[k] & global_ie_i & (line_prio[k] > threshold_i);
        end
    end

    // Ascending scan with >= lets the highest index win a priority tie.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        for (int k = 0; k < NUM_INTERRUPTS; k++) begin
            if (cand[k] && (!win_found || line_prio[k] >= win_prio)) begin
                win_found = 1'b1;
                win_id    = 5'(k);
                win_prio  = line_prio[k];
            end
        end
    end

    always_comb begin
        lat_cand = 1'b0;
        lat_edge = 1'b0;
        for (int k = 0; k < NUM_INTERRUPTS; k++) begin
            if (irq_id_q == 5'(k)) begin
                lat_cand = cand[k];
                lat_edge = irq_edge_i[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        irq_prio_d = irq_prio_q;
        ack_take   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d    = S_REQ;
                    irq_id_d   = win_id;
                    irq_prio_d = win_prio;
                end
            end
            S_REQ: begin
                if (irq_ack_i) begin
                    state_d  = S_ACKED;
                    ack_take = 1'b1;
                end else if (!lat_cand) begin
                    state_d = S_IDLE;
                end
            end
            S_ACKED: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A new edge on the line being acknowledged wins over the clear.
    always_comb begin
        for (int k = 0; k < NUM_INTERRUPTS; k++) begin
            pend_clr[k] = ack_take && lat_edge && (irq_id_q == 5'(k));
        end
        pend_d = (pend_q & ~pend_clr) | (irq_q & ~irq_prev_q & irq_edge_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            irq_prev_q <= '0;
            pend_q     <= '0;
            irq_id_q   <= '0;
            irq_prio_q <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_q;
            pend_q     <= pend_d;
            irq_id_q   <= irq_id_d;
            irq_prio_q <= irq_prio_d;
        end
    end

    assign irq_req_o  = (state_q == S_REQ);
    assign irq_id_o   = irq_id_q;
    assign irq_prio_o = irq_prio_q;

endmodule

// File: tb/tb_cv32e40p_prio_int_controller.sv
// Directed bench: expected offers go into a queue, a negedge monitor checks each new irq_req_o offer.
module tb_cv32e40p_prio_int_controller;

    localparam int N = 32;
    localparam int P = 3;

    logic           clk;
    logic           clk_run;
    logic           rst_n;
    logic [N-1:0]   irq_i;
    logic [N-1:0]   irq_edge_i;
    logic [N*P-1:0] irq_prio_i;
    logic [N-1:0]   irq_enable_i;
    logic           global_ie_i;
    logic [P-1:0]   threshold_i;
    logic           irq_ack_i;
    logic           irq_req_o;
    logic [4:0]     irq_id_o;
    logic [P-1:0]   irq_prio_o;
    logic [N-1:0]   pending_o;
    logic           irq_wu_o;

    cv32e40p_prio_int_controller #(.NUM_INTERRUPTS(N), .PRIO_WIDTH(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_i        (irq_i),
        .irq_edge_i   (irq_edge_i),
        .irq_prio_i   (irq_prio_i),
        .irq_enable_i (irq_enable_i),
        .global_ie_i  (global_ie_i),
        .threshold_i  (threshold_i),
        .irq_ack_i    (irq_ack_i),
        .irq_req_o    (irq_req_o),
        .irq_id_o     (irq_id_o),
        .irq_prio_o   (irq_prio_o),
        .pending_o    (pending_o),
        .irq_wu_o     (irq_wu_o)
    );

    typedef struct {
        int id;
        int prio;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic prev_req = 1'b0;

    initial clk = 1'b0;
    always #5 clk = clk_run ? ~clk : clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every new offer must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && irq_req_o && !prev_req) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_req: id=%0d prio=%0d cyc=%0d, required no request", irq_id_o, irq_prio_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(irq_id_o) != e.id || int'(irq_prio_o) != e.prio || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL offer: got id=%0d prio=%0d cyc=%0d, required id=%0d prio=%0d cyc=%0d",
                             irq_id_o, irq_prio_o, cyc, e.id, e.prio, e.cyc);
                end
            end
        end
        prev_req = rst_n && irq_req_o;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_offer(input int id, input int prio, input int at_cyc);
        exp_t e;
        e.id = id; e.prio = prio; e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic set_prio(input int k, input int p);
        irq_prio_i[k*P +: P] = P'(p);
    endtask

    task automatic wait_req(input string name, input int limit);
        int n = 0;
        while (!irq_req_o && n < limit) begin
            tick();
            n++;
        end
        chk(name, irq_req_o, 1'b1);
    endtask

    // Ack for one cycle, dropping the given lines on the same edge.
    task automatic do_ack(input string name, input logic [N-1:0] drop);
        irq_ack_i = 1'b1;
        irq_i     = irq_i & ~drop;
        tick();
        irq_ack_i = 1'b0;
        chk(name, irq_req_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        clk_run      = 1'b1;
        rst_n        = 1'b0;
        irq_i        = '0;
        irq_edge_i   = '0;
        irq_prio_i   = '0;
        irq_enable_i = '0;
        global_ie_i  = 1'b1;
        threshold_i  = '0;
        irq_ack_i    = 1'b0;
        #12;
        chk("rst_req", irq_req_o, 1'b0);
        chk("rst_id", irq_id_o, 5'd0);
        chk("rst_prio", irq_prio_o, 3'd0);
        chk("rst_pending", pending_o, '0);
        tick();
        rst_n = 1'b1;
        tick(2);

        // Level line 7: request at +2, ack, re-request while still high.
        set_prio(7, 2);
        irq_enable_i[7] = 1'b1;
        expect_offer(7, 2, cyc + 2);
        irq_i[7] = 1'b1;
        wait_req("lvl_req", 10);
        expect_offer(7, 2, cyc + 3);
        do_ack("lvl_acked_low", '0);
        wait_req("lvl_rereq", 10);
        do_ack("lvl_ack2_low", N'(1) << 7);
        tick(4);

        // Edge line 3: one-cycle pulse, sticky pending, request at +3, cleared by ack.
        irq_edge_i[3]   = 1'b1;
        irq_enable_i[3] = 1'b1;
        set_prio(3, 1);
        expect_offer(3, 1, cyc + 3);
        irq_i[3] = 1'b1;
        tick();
        irq_i[3] = 1'b0;
        wait_req("edge_req", 10);
        chk("edge_pending_set", pending_o[3], 1'b1);
        do_ack("edge_acked_low", '0);
        chk("edge_pending_clr", pending_o[3], 1'b0);
        tick(5);
        chk("edge_no_rereq", irq_req_o, 1'b0);

        // Tie 5/9 -> 9; higher-priority line 2 waits for the ack.
        set_prio(5, 4);
        set_prio(9, 4);
        set_prio(2, 6);
        irq_enable_i[5] = 1'b1;
        irq_enable_i[9] = 1'b1;
        irq_enable_i[2] = 1'b1;
        expect_offer(9, 4, cyc + 2);
        irq_i[5] = 1'b1;
        irq_i[9] = 1'b1;
        wait_req("tie_req", 10);
        irq_i[2] = 1'b1;
        tick(4);
        chk("noarb_req", irq_req_o, 1'b1);
        chk("noarb_id", irq_id_o, 5'd9);
        chk("noarb_prio", irq_prio_o, 3'd4);
        expect_offer(2, 6, cyc + 3);
        do_ack("tie_acked_low", '0);
        wait_req("hi_req", 10);
        do_ack("hi_acked_low", (N'(1) << 2) | (N'(1) << 5) | (N'(1) << 9));
        tick(4);

        // Threshold is strict; a stray ack in IDLE changes nothing.
        set_prio(1, 4);
        irq_enable_i[1] = 1'b1;
        threshold_i = 3'd4;
        irq_i[1] = 1'b1;
        tick(2);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        tick(3);
        chk("thr_equal_noreq", irq_req_o, 1'b0);
        chk("thr_pending", pending_o[1], 1'b1);
        expect_offer(1, 4, cyc + 1);
        threshold_i = 3'd3;
        wait_req("thr_req", 10);
        do_ack("thr_acked_low", N'(1) << 1);
        threshold_i = '0;
        tick(4);

        // Global enable drop retracts, id holds; restore brings the offer back.
        set_prio(4, 3);
        irq_enable_i[4] = 1'b1;
        expect_offer(4, 3, cyc + 2);
        irq_i[4] = 1'b1;
        wait_req("gie_req", 10);
        global_ie_i = 1'b0;
        tick();
        chk("gie_retract", irq_req_o, 1'b0);
        chk("gie_id_hold", irq_id_o, 5'd4);
        expect_offer(4, 3, cyc + 1);
        global_ie_i = 1'b1;
        wait_req("gie_return", 10);
        do_ack("gie_acked_low", N'(1) << 4);
        tick(4);

        // Wake-up with the clock stopped, ignoring global enable and threshold.
        @(negedge clk);
        clk_run = 1'b0;
        #20;
        global_ie_i = 1'b0;
        threshold_i = 3'd7;
        irq_enable_i[11] = 1'b1;
        irq_i[11] = 1'b1;
        #1;
        chk("wu_on", irq_wu_o, 1'b1);
        irq_enable_i[11] = 1'b0;
        #1;
        chk("wu_masked", irq_wu_o, 1'b0);
        irq_i[11] = 1'b0;
        global_ie_i = 1'b1;
        threshold_i = '0;
        #4;
        clk_run = 1'b1;
        tick(2);

        // Async reset mid-REQ with an edge event pending behind the offer.
        set_prio(6, 5);
        irq_enable_i[6] = 1'b1;
        expect_offer(6, 5, cyc + 2);
        irq_i[6] = 1'b1;
        wait_req("rst_case_req", 10);
        irq_i[3] = 1'b1;
        tick();
        irq_i[3] = 1'b0;
        tick();
        chk("rst_case_pend3", pending_o[3], 1'b1);
        chk("rst_case_id", irq_id_o, 5'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", irq_req_o, 1'b0);
        chk("mid_rst_id", irq_id_o, 5'd0);
        chk("mid_rst_prio", irq_prio_o, 3'd0);
        chk("mid_rst_pending", pending_o, '0);
        irq_i = '0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_noreq", irq_req_o, 1'b0);
        chk("post_rst_pending", pending_o, '0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
